// File: rtl/result_writeback_pkg.sv
// Shared parameters and FSM encoding for the result writeback stage.
// Sizes are fixed by the upstream matmul array (16 lanes of int16 accumulators)
// and the output buffer geometry (256-bit words, 8-bit word address).
package result_writeback_pkg;

  localparam int unsigned LANES  = 16;
  localparam int unsigned ACC_W  = 16;
  localparam int unsigned Q_W    = 8;
  localparam int unsigned ADDR_W = 8;
  localparam int unsigned ROW_W  = LANES * ACC_W;  // 256-bit accumulator row
  localparam int unsigned HALF_W = LANES * Q_W;    // 128-bit requantized row
  localparam int unsigned CNT_W  = 5;              // row count, m = 0..31

  typedef enum logic [1:0] {
    StIdle,
    StCollect,
    StDrain
  } state_e;

endpackage

// File: rtl/requant_lane.sv
// Combinational requantizer for one accumulator lane.
//   x_i     : signed ACC_W accumulator value
//   shift_i : arithmetic right shift amount (0..15), round-half-up when non-zero
//   y_o     : signed Q_W result, saturated to [-128, 127]
module requant_lane
  import result_writeback_pkg::*;
(
  input  logic [ACC_W-1:0] x_i,
  input  logic [3:0]       shift_i,
  output logic [Q_W-1:0]   y_o
);

  // One extra bit of headroom so x + rounding constant cannot overflow.
  logic signed [ACC_W:0] x_ext;
  logic signed [ACC_W:0] rnd;
  logic signed [ACC_W:0] sum;
  logic signed [ACC_W:0] shifted;

  always_comb begin
    x_ext = $signed({x_i[ACC_W-1], x_i});
    rnd   = '0;
    if (shift_i != 4'd0) begin
      rnd[shift_i - 4'd1] = 1'b1;
    end
    sum     = x_ext + rnd;
    shifted = sum >>> shift_i;
    if (shifted > 17'sd127) begin
      y_o = 8'h7f;
    end else if (shifted < -17'sd128) begin
      y_o = 8'h80;
    end else begin
      y_o = shifted[Q_W-1:0];
    end
  end

endmodule

// File: rtl/result_writeback.sv
// Result writeback: requantizes int16 accumulator rows to int8, packs two rows
// per 256-bit word and writes the words to the output global buffer.
//   clk, rst_n           : clock, asynchronous active-low reset
//   in_valid, m,
//   base_addr, shift     : job start pulse and its configuration
//   out_valid, gbuff_out : incoming accumulator row stream
//   wr_en, wr_addr,
//   wr_data              : output buffer write port (no back-pressure)
//   busy, done           : job status; done pulses with the final write
module result_writeback
  import result_writeback_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [4:0]        m,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [3:0]        shift,
  input  logic              out_valid,
  input  logic [ROW_W-1:0]  gbuff_out,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [ROW_W-1:0]  wr_data,
  output logic              busy,
  output logic              done
);

  state_e              state_q;
  logic [CNT_W-1:0]    m_q;
  logic [ADDR_W-1:0]   base_q;
  logic [3:0]          shift_q;
  logic [CNT_W-1:0]    row_cnt_q;
  logic [ADDR_W-1:0]   word_cnt_q;

  // Requant pipeline stage: one registered int8 row plus its position tags.
  logic [HALF_W-1:0]   qrow_q;
  logic                qvalid_q;
  logic                qodd_q;
  logic                qlast_q;

  // Even-indexed row waiting for its odd partner.
  logic [HALF_W-1:0]   hold_q;

  logic [HALF_W-1:0]   q_row;
  logic                start;
  logic                accept;
  logic                last_row;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    requant_lane u_lane (
      .x_i     (gbuff_out[i*ACC_W +: ACC_W]),
      .shift_i (shift_q),
      .y_o     (q_row[i*Q_W +: Q_W])
    );
  end

  // A start is only taken when fully idle, including the done cycle of an
  // m=0 job where busy is still high.
  assign start    = in_valid && (state_q == StIdle) && !busy;
  assign accept   = (state_q == StCollect) && out_valid && (row_cnt_q < m_q);
  assign last_row = (row_cnt_q == m_q - 5'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      m_q        <= '0;
      base_q     <= '0;
      shift_q    <= '0;
      row_cnt_q  <= '0;
      word_cnt_q <= '0;
      qrow_q     <= '0;
      qvalid_q   <= 1'b0;
      qodd_q     <= 1'b0;
      qlast_q    <= 1'b0;
      hold_q     <= '0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      wr_en    <= 1'b0;
      done     <= 1'b0;
      qvalid_q <= accept;

      if (accept) begin
        qrow_q    <= q_row;
        qodd_q    <= row_cnt_q[0];
        qlast_q   <= last_row;
        row_cnt_q <= row_cnt_q + 5'd1;
      end

      // Pack stage: odd rows complete a word; a final even row (odd m) is
      // written alone with a zero upper half.
      if (qvalid_q) begin
        if (qodd_q || qlast_q) begin
          wr_en      <= 1'b1;
          wr_addr    <= base_q + word_cnt_q;
          wr_data    <= qodd_q ? {qrow_q, hold_q} : {{HALF_W{1'b0}}, qrow_q};
          word_cnt_q <= word_cnt_q + 1'b1;
        end else begin
          hold_q <= qrow_q;
        end
        if (qlast_q) begin
          done <= 1'b1;
        end
      end

      if (done) begin
        busy <= 1'b0;
      end

      unique case (state_q)
        StIdle: begin
          if (start) begin
            m_q        <= m;
            base_q     <= base_addr;
            shift_q    <= shift;
            row_cnt_q  <= '0;
            word_cnt_q <= '0;
            hold_q     <= '0;
            busy       <= 1'b1;
            if (m == 5'd0) begin
              done <= 1'b1;
            end else begin
              state_q <= StCollect;
            end
          end
        end
        StCollect: begin
          if (accept && last_row) begin
            state_q <= StDrain;
          end
        end
        StDrain: begin
          // Leave once the final write (signalled by done) has gone out.
          if (done) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
